// File: rtl/mem_arbiter_if.sv
// Bundle of the IF, LSU and memory-port signals around mem_arbiter.
// slave: arbiter side. master: requesters plus memory model side.
interface mem_arbiter_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid;
    logic [31:0] if_rdata;

    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_wen;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [63:0] lsu_rdata;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  if_req_valid, if_addr,
        output if_req_ready, if_resp_valid, if_rdata,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata,
        output mem_r_en, mem_w_en, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_addr,
        input  if_req_ready, if_resp_valid, if_rdata,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
        input  mem_r_en, mem_w_en, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IF and LSU.
// MEM_ARBITER_RR_EN selects round-robin tie-break; default is LSU priority.
module mem_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        lsu_gnt_q, lsu_gnt_d;
    logic        wen_q, wen_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wmask_q, wmask_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_pick, lsu_rdy, if_rdy, mem_fire;

`ifdef MEM_ARBITER_RR_EN
    logic last_lsu_q, last_lsu_d;
    // On contention the requester not granted last time wins.
    assign lsu_pick = bus.lsu_req_valid && !(bus.if_req_valid && last_lsu_q);
`else
    assign lsu_pick = bus.lsu_req_valid;
`endif

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign lsu_rdy = rst_n && (state_q == IDLE) && lsu_pick;
    assign if_rdy  = rst_n && (state_q == IDLE) && bus.if_req_valid && !lsu_pick;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lsu_gnt_d   = lsu_gnt_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        mem_fire    = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        last_lsu_d  = last_lsu_q;
`endif
        case (state_q)
            IDLE: begin
                if (lsu_rdy || if_rdy) begin
                    state_d   = ACCESS;
                    cnt_d     = CNT_LOAD;
                    lsu_gnt_d = lsu_rdy;
`ifdef MEM_ARBITER_RR_EN
                    last_lsu_d = lsu_rdy;
`endif
                    if (lsu_rdy) begin
                        wen_d   = bus.lsu_wen;
                        addr_d  = bus.lsu_addr;
                        wdata_d = bus.lsu_wdata;
                        wmask_d = bus.lsu_wmask;
                    end else begin
                        wen_d   = 1'b0;
                        addr_d  = bus.if_addr;
                        wmask_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_fire = 1'b1;
                    state_d  = RESP;
                    if (!wen_q) begin
                        if (lsu_gnt_q) lsu_rdata_d = bus.mem_rdata;
                        else           if_rdata_d  = addr_q[2] ? bus.mem_rdata[63:32]
                                                               : bus.mem_rdata[31:0];
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lsu_gnt_q   <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
`ifdef MEM_ARBITER_RR_EN
            last_lsu_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lsu_gnt_q   <= lsu_gnt_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
`ifdef MEM_ARBITER_RR_EN
            last_lsu_q  <= last_lsu_d;
`endif
        end
    end

    // IF address keeps its low bits in addr_q for the half-word select; the port sees it aligned.
    assign bus.if_req_ready   = if_rdy;
    assign bus.lsu_req_ready  = lsu_rdy;
    assign bus.if_resp_valid  = rst_n && (state_q == RESP) && !lsu_gnt_q;
    assign bus.lsu_resp_valid = rst_n && (state_q == RESP) && lsu_gnt_q;
    assign bus.if_rdata       = rst_n ? if_rdata_q : '0;
    assign bus.lsu_rdata      = rst_n ? lsu_rdata_q : '0;
    assign bus.mem_r_en       = rst_n && mem_fire && !wen_q;
    assign bus.mem_w_en       = rst_n && mem_fire && wen_q;
    assign bus.mem_wmask      = (rst_n && mem_fire && wen_q) ? wmask_q : '0;
    assign bus.mem_addr       = !rst_n    ? '0
                              : lsu_gnt_q ? addr_q
                                          : {addr_q[63:3], 3'b000};
    assign bus.mem_wdata      = rst_n ? wdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-timing model (accept at t, enable at t+LAT, response at t+LAT+1).
module tb_mem_arbiter;
    localparam int unsigned LAT  = 3;
    localparam int          LATI = LAT;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Model state: one transaction, described by its accept cycle.
    bit          m_busy;
    int          m_acc;
    bit          m_lsu, m_wen, m_hi;
    logic [63:0] m_addr, m_wdata, m_lsu_rd;
    logic [7:0]  m_wmask;
    logic [31:0] m_if_rd;
`ifdef MEM_ARBITER_RR_EN
    bit          m_last_lsu;
`endif

    always @(negedge clk) begin : model
        bit en, resp, lsu_win, e_ir, e_lr;
        cyc++;
        e_ir = 1'b0;
        e_lr = 1'b0;
        en   = 1'b0;
        resp = 1'b0;
        if (rst_n) begin
`ifdef MEM_ARBITER_RR_EN
            lsu_win = bus.lsu_req_valid && !(bus.if_req_valid && m_last_lsu);
`else
            lsu_win = bus.lsu_req_valid;
`endif
            e_lr = !m_busy && lsu_win;
            e_ir = !m_busy && bus.if_req_valid && !lsu_win;
            en   = m_busy && (cyc == m_acc + LATI);
            resp = m_busy && (cyc == m_acc + LATI + 1);
        end
        if (chk_on) begin
            chk("if_req_ready",   64'(bus.if_req_ready),   64'(e_ir));
            chk("lsu_req_ready",  64'(bus.lsu_req_ready),  64'(e_lr));
            chk("if_resp_valid",  64'(bus.if_resp_valid),  64'(resp && !m_lsu));
            chk("lsu_resp_valid", 64'(bus.lsu_resp_valid), 64'(resp && m_lsu));
            chk("mem_r_en",       64'(bus.mem_r_en),       64'(en && !(m_lsu && m_wen)));
            chk("mem_w_en",       64'(bus.mem_w_en),       64'(en && m_lsu && m_wen));
            chk("mem_wmask",      64'(bus.mem_wmask),      (en && m_lsu && m_wen) ? 64'(m_wmask) : 64'd0);
            chk("mem_addr",       bus.mem_addr,            rst_n ? m_addr : 64'd0);
            chk("mem_wdata",      bus.mem_wdata,           rst_n ? m_wdata : 64'd0);
            chk("if_rdata",       64'(bus.if_rdata),       rst_n ? 64'(m_if_rd) : 64'd0);
            chk("lsu_rdata",      bus.lsu_rdata,           rst_n ? m_lsu_rd : 64'd0);
        end
        if (!rst_n) begin
            m_busy = 1'b0; m_lsu = 1'b0; m_wen = 1'b0; m_hi = 1'b0;
            m_addr = '0; m_wdata = '0; m_wmask = '0; m_lsu_rd = '0; m_if_rd = '0;
`ifdef MEM_ARBITER_RR_EN
            m_last_lsu = 1'b1;
`endif
        end else begin
            if (en && !(m_lsu && m_wen)) begin
                if (m_lsu) m_lsu_rd = bus.mem_rdata;
                else       m_if_rd  = m_hi ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
            end
            if (resp) m_busy = 1'b0;
            if (e_lr || e_ir) begin
                m_busy = 1'b1;
                m_acc  = cyc;
                m_lsu  = e_lr;
`ifdef MEM_ARBITER_RR_EN
                m_last_lsu = e_lr;
`endif
                if (e_lr) begin
                    m_wen = bus.lsu_wen;   m_addr  = bus.lsu_addr;
                    m_wdata = bus.lsu_wdata; m_wmask = bus.lsu_wmask;
                end else begin
                    m_wen = 1'b0; m_wmask = '0;
                    m_addr = bus.if_addr & ~64'h7;
                    m_hi   = bus.if_addr[2];
                end
            end
        end
    end

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        bus.if_req_valid  = 1'b0;
        bus.lsu_req_valid = 1'b0;
        repeat (n) nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_r, n_w, n_ifr, n_lsr, en_k, rsp_k, ng, nboth;
        logic [63:0] cap_addr, cap_wdata, cap_rd;
        logic [7:0]  cap_mask;
        int          gk[3];
        bit          gl[3];

        rst_n = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_addr  = 64'h8000_0010;
        bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0;
        bus.lsu_addr = 64'h8000_2000; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.mem_rdata = 64'h0;
        nxt();
        chk_on = 1'b1;

        // Reset held with both valids high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_if_ready",  64'(bus.if_req_ready),  64'd0);
            chk("rst_lsu_ready", 64'(bus.lsu_req_ready), 64'd0);
            chk("rst_mem_addr",  bus.mem_addr,           64'd0);
            nxt();
        end
        rst_n = 1'b1;
        @(negedge clk);
`ifdef MEM_ARBITER_RR_EN
        chk("rel_if_ready",  64'(bus.if_req_ready),  64'd1);
        chk("rel_lsu_ready", 64'(bus.lsu_req_ready), 64'd0);
`else
        chk("rel_if_ready",  64'(bus.if_req_ready),  64'd0);
        chk("rel_lsu_ready", 64'(bus.lsu_req_ready), 64'd1);
`endif
        nxt();

        // IF read of the upper word
        do_reset(2);
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0004;
        bus.mem_rdata = 64'h1122_3344_5566_7788;
        @(negedge clk);
        chk("ifrd_accept", 64'(bus.if_req_ready), 64'd1);
        n_r = 0; n_w = 0; en_k = -1; rsp_k = -1; cap_addr = '0; cap_rd = '0;
        for (int k = 1; k <= LATI + 2; k++) begin
            nxt();
            if (k == 1) bus.if_req_valid = 1'b0;
            @(negedge clk);
            if (bus.mem_r_en) begin n_r++; en_k = k; cap_addr = bus.mem_addr; end
            if (bus.mem_w_en) n_w++;
            if (bus.if_resp_valid) begin rsp_k = k; cap_rd = 64'(bus.if_rdata); end
        end
        nxt();
        chk("ifrd_ren_count", 64'(n_r),   64'd1);
        chk("ifrd_wen_count", 64'(n_w),   64'd0);
        chk("ifrd_en_cycle",  64'(en_k),  64'd3);
        chk("ifrd_mem_addr",  cap_addr,   64'h8000_0000);
        chk("ifrd_resp_cyc",  64'(rsp_k), 64'd4);
        chk("ifrd_rdata",     cap_rd,     64'h1122_3344);

        // LSU write
        do_reset(2);
        bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1;
        bus.lsu_addr = 64'h8000_1000; bus.lsu_wdata = 64'hdead_beef; bus.lsu_wmask = 8'h0f;
        @(negedge clk);
        chk("wr_accept", 64'(bus.lsu_req_ready), 64'd1);
        n_r = 0; n_w = 0; n_ifr = 0; en_k = -1; rsp_k = -1; cap_mask = '0; cap_wdata = '0; cap_rd = 64'hx;
        for (int k = 1; k <= LATI + 2; k++) begin
            nxt();
            if (k == 1) bus.lsu_req_valid = 1'b0;
            @(negedge clk);
            if (bus.mem_r_en) n_r++;
            if (bus.mem_w_en) begin n_w++; en_k = k; cap_mask = bus.mem_wmask; cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata; end
            if (bus.if_resp_valid) n_ifr++;
            if (bus.lsu_resp_valid) begin rsp_k = k; cap_rd = bus.lsu_rdata; end
        end
        nxt();
        chk("wr_wen_count", 64'(n_w),   64'd1);
        chk("wr_ren_count", 64'(n_r),   64'd0);
        chk("wr_en_cycle",  64'(en_k),  64'd3);
        chk("wr_wmask",     64'(cap_mask), 64'h0f);
        chk("wr_addr",      cap_addr,   64'h8000_1000);
        chk("wr_wdata",     cap_wdata,  64'hdead_beef);
        chk("wr_resp_cyc",  64'(rsp_k), 64'd4);
        chk("wr_rdata_kept", cap_rd,    64'd0);
        chk("wr_if_resp",   64'(n_ifr), 64'd0);

        // Both valids held: three grants, spaced LAT+2 apart
        do_reset(2);
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0040;
        bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0; bus.lsu_addr = 64'h8000_3000;
        ng = 0; nboth = 0;
        for (int k = 0; k < 3 * (LATI + 2); k++) begin
            @(negedge clk);
            if (bus.if_req_ready && bus.lsu_req_ready) nboth++;
            if ((bus.if_req_ready || bus.lsu_req_ready) && ng < 3) begin
                gk[ng] = k; gl[ng] = bus.lsu_req_ready; ng++;
            end
            nxt();
        end
        chk("tie_grants", 64'(ng), 64'd3);
        chk("tie_both_ready", 64'(nboth), 64'd0);
        chk("tie_spacing", {32'(gk[1]), 32'(gk[2])}, {32'd5, 32'd10});
`ifdef MEM_ARBITER_RR_EN
        chk("tie_order", 64'({gl[0], gl[1], gl[2]}), 64'b010);
`else
        chk("tie_order", 64'({gl[0], gl[1], gl[2]}), 64'b111);
`endif

        // Reset during ACCESS of a write, then a read right after release
        do_reset(2);
        bus.if_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b1;
        bus.lsu_addr = 64'h8000_1008; bus.lsu_wdata = 64'h55; bus.lsu_wmask = 8'hff;
        @(negedge clk);
        chk("rsta_accept", 64'(bus.lsu_req_ready), 64'd1);
        n_w = 0; n_lsr = 0; rsp_k = -1;
        nxt();
        bus.lsu_req_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        if (bus.mem_w_en) n_w++;
        if (bus.lsu_resp_valid) n_lsr++;
        nxt();
        rst_n = 1'b1; bus.lsu_req_valid = 1'b1; bus.lsu_wen = 1'b0;
        @(negedge clk);
        chk("rsta_idle_after", 64'(bus.lsu_req_ready), 64'd1);
        for (int k = 3; k <= LATI + 4; k++) begin
            nxt();
            if (k == 3) bus.lsu_req_valid = 1'b0;
            @(negedge clk);
            if (bus.mem_w_en) n_w++;
            if (bus.lsu_resp_valid) begin n_lsr++; rsp_k = k; end
        end
        nxt();
        chk("rsta_no_wen",   64'(n_w),   64'd0);
        chk("rsta_resp_cnt", 64'(n_lsr), 64'd1);
        chk("rsta_resp_cyc", 64'(rsp_k), 64'd6);

        // Continuous IF valid
        do_reset(2);
        bus.if_req_valid = 1'b1; bus.if_addr = 64'h8000_0100;
        ng = 0; n_r = 0;
        for (int k = 0; k < 3 * (LATI + 2); k++) begin
            @(negedge clk);
            if (bus.mem_r_en) n_r++;
            if (bus.if_req_ready && ng < 3) begin gk[ng] = k; ng++; end
            nxt();
        end
        chk("cont_accepts", 64'(ng), 64'd3);
        chk("cont_cycles", {16'(gk[0]), 16'(gk[1]), 32'(gk[2])}, {16'd0, 16'd5, 32'd10});
        chk("cont_ren_count", 64'(n_r), 64'd3);

        // Random traffic checked cycle by cycle by the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.if_req_valid = ($urandom_range(0, 2) != 0);
                bus.if_addr      = {$urandom, $urandom} & ~64'h3;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.lsu_req_valid = ($urandom_range(0, 2) != 0);
                bus.lsu_wen       = $urandom_range(0, 1) != 0;
                bus.lsu_addr      = {$urandom, $urandom};
                bus.lsu_wdata     = {$urandom, $urandom};
                bus.lsu_wmask     = 8'($urandom);
            end
            bus.mem_rdata = {$urandom, $urandom};
            nxt();
        end
        bus.if_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        repeat (LATI + 3) nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
